lcd_cmd_sequencer: RTL and testbench
====================================

// Module: lcd_cmd_sequencer
// PURPOSE
//  Buffers image-op commands from a host and issues them one at a time to the LCD image controller.
//  Issue follows the controller's cmd/cmd_valid/busy protocol, and the sequencer tracks the final write (cmd 0) to completion.
//  Sits between the host/testbench command source and LCD_CTRL; owns all cmd sequencing and cmd gating.
// PARAMETERS
//  FIFO_DEPTH  8      command FIFO entries (power of 2, >=2)
//  NOP_CODE    4'hF   code driven on lcd_cmd while not issuing (no datapath effect downstream)
//  MAX_CMD     4'd11  highest legal command code; codes above it are rejected
//  CNT_W       8      width of issued-command counter
// PORTS
//  clk          in   1      system clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  in_cmd       in   4      host command code
//  in_valid     in   1      host command strobe; accepted when in_valid & in_ready
//  in_ready     out  1      FIFO can accept (not full, not FINISH)
//  lcd_busy     in   1      controller busy (high during image load and per op)
//  lcd_done     in   1      controller write-back complete
//  lcd_cmd      out  4      command to controller; NOP_CODE unless lcd_cmd_valid
//  lcd_cmd_valid out 1      one-cycle issue strobe
//  seq_done     out  1      sticky: write command completed
//  issued_cnt   out  CNT_W  commands issued since reset, saturating
//  err_illegal  out  1      sticky: a code > MAX_CMD was offered and dropped
// BEHAVIOUR
//  Reset (async): state IDLE, FIFO empty, lcd_cmd=NOP_CODE, lcd_cmd_valid=0, seq_done=0, issued_cnt=0, err_illegal=0.
//   in_ready=1 during reset; reset mid-operation discards all queued commands.
//  Downstream acts on the lcd_cmd level, not only on the strobe. lcd_cmd==NOP_CODE on every cycle lcd_cmd_valid==0, registered, no glitch.
//  Push: in_valid & in_ready & in_cmd<=MAX_CMD -> enqueue.
//   in_cmd>MAX_CMD -> not enqueued; err_illegal<=1; handshake still completes (in_ready unaffected).
//  in_ready = !full & state!=FINISH. A pop in the same cycle does not free a slot for that cycle.
//  FSM (all outputs registered):
//   IDLE: FIFO non-empty & !lcd_busy -> pop head, load lcd_cmd, lcd_cmd_valid<=1 -> ISSUE.
//   ISSUE (1 cycle, strobe high): lcd_cmd<=NOP_CODE, lcd_cmd_valid<=0, issued_cnt++ (saturate at all-ones).
//    Next state: WAIT_DONE if the issued code==0, else GUARD.
//   GUARD (1 cycle): ignores lcd_busy (controller raises busy the cycle after sampling) -> WAIT_BUSY.
//   WAIT_BUSY: !lcd_busy -> IDLE. Back-to-back issue gap is therefore >=3 cycles.
//   WAIT_DONE: lcd_done -> seq_done<=1 -> FINISH.
//   FINISH: terminal until reset. Pops nothing; in_ready=0; residual FIFO content is retained but never issued.
//  Latency: FIFO non-empty & !lcd_busy sampled in IDLE -> lcd_cmd_valid high on the next cycle.
//  Push into an empty FIFO while IDLE & !lcd_busy: visible to pop 1 cycle after acceptance.
//  Push and pop in the same cycle (non-full): both occur; count unchanged.
//  lcd_busy high from reset (image load): no issue until it falls. Commands queue meanwhile.
//  FIFO: pointers wrap mod FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
// STRUCTURE
//  lcd_pkg: command code localparams (CMD_WRITE=0 .. CMD_MIRROR_Y=11), NOP_CODE, FSM state encoding.
//  Sub-module cmd_fifo: sync FIFO, 4-bit data, FIFO_DEPTH entries, push/pop/full/empty/count.
//  Top: FSM, output registers, counters.
// TESTING
//  1 Hold lcd_busy=1 for 64 cycles after reset, then push 1,5,0 -> no strobe while busy.
//    lcd_cmd_valid rises 1 cycle after busy falls, with lcd_cmd=1.
//  2 Push 4'd13 -> FIFO count stays 0, err_illegal=1, issued_cnt=0, lcd_cmd stays 4'hF.
//  3 Keep lcd_busy=1 and push 9 cmds of code 4 -> in_ready=0 after the 8th; the 9th is not accepted.
//  4 Model with 1-cycle busy per op; issue 2,3,7 -> strobes >=3 cycles apart.
//    lcd_cmd sequence 2,3,7 and issued_cnt=3.
//  5 Issue 0, assert lcd_done 66 cycles later -> seq_done=1 next cycle.
//    in_ready=0 thereafter; a later push is not issued.
//  6 Assert reset during WAIT_BUSY with 3 queued -> outputs at reset values immediately.
//    After release, no strobe occurs until new pushes arrive.
//  All tests: assert lcd_cmd==4'hF on every cycle with lcd_cmd_valid==0.

Source files
------------

// File: rtl/lcd_cmd_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_cmd_sequencer_pkg : command codes and FSM encoding               |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package lcd_cmd_sequencer_pkg;

  localparam logic [3:0] CMD_WRITE      = 4'd0;
  localparam logic [3:0] CMD_SHIFT_UP   = 4'd1;
  localparam logic [3:0] CMD_SHIFT_DOWN = 4'd2;
  localparam logic [3:0] CMD_SHIFT_LEFT = 4'd3;
  localparam logic [3:0] CMD_SHIFT_RGT  = 4'd4;
  localparam logic [3:0] CMD_MAX        = 4'd5;
  localparam logic [3:0] CMD_MIN        = 4'd6;
  localparam logic [3:0] CMD_AVERAGE    = 4'd7;
  localparam logic [3:0] CMD_ROT_CCW    = 4'd8;
  localparam logic [3:0] CMD_ROT_CW     = 4'd9;
  localparam logic [3:0] CMD_MIRROR_X   = 4'd10;
  localparam logic [3:0] CMD_MIRROR_Y   = 4'd11;

  localparam logic [3:0] DEF_NOP_CODE   = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_GUARD     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_FINISH    = 3'd5
  } seq_state_t;

  function automatic logic cmd_is_legal(input logic [3:0] code, input logic [3:0] max_code);
    return (code <= max_code);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_cmd_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_cmd_sequencer_if : host command valid/ready stream               |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface lcd_cmd_sequencer_if;
  logic [3:0] in_cmd;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_cmd, output in_valid, input in_ready);
  modport slave  (input in_cmd, input in_valid, output in_ready);
endinterface
`default_nettype wire

// File: rtl/lcd_cmd_sequencer_cmd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_cmd_sequencer_cmd_fifo : synchronous 4-bit command FIFO          |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module lcd_cmd_sequencer_cmd_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          push,
  input  wire logic [3:0]    din,
  input  wire logic          pop,
  output logic      [3:0]    dout,
  output logic               empty,
  output logic      [CW-1:0] count
);

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_cmd_sequencer : queues host commands, issues them to LCD_CTRL    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module lcd_cmd_sequencer
  import lcd_cmd_sequencer_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [3:0] NOP_CODE   = DEF_NOP_CODE,
  parameter logic [3:0] MAX_CMD    = CMD_MIRROR_Y,
  parameter int         CNT_W      = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  lcd_cmd_sequencer_if.slave    host,
  input  wire logic             lcd_busy,
  input  wire logic             lcd_done,
  output logic      [3:0]       lcd_cmd,
  output logic                  lcd_cmd_valid,
  output logic                  seq_done,
  output logic      [CNT_W-1:0] issued_cnt,
  output logic                  err_illegal
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  seq_state_t    state;
  logic [3:0]    fifo_head;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          accept;
  logic          legal;
  logic          push;
  logic          pop;

  assign fifo_full     = (fifo_count == CW'(FIFO_DEPTH));
  assign host.in_ready = !fifo_full && (state != ST_FINISH);
  assign accept        = host.in_valid && host.in_ready;
  assign legal         = cmd_is_legal(host.in_cmd, MAX_CMD);
  assign push          = accept && legal;
  assign pop           = (state == ST_IDLE) && !fifo_empty && !lcd_busy;

  lcd_cmd_sequencer_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (host.in_cmd),
    .pop   (pop),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // lcd_cmd still holds the issued code during ISSUE, so it selects the successor state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      lcd_cmd       <= NOP_CODE;
      lcd_cmd_valid <= 1'b0;
      seq_done      <= 1'b0;
      issued_cnt    <= '0;
      err_illegal   <= 1'b0;
    end else begin
      if (accept && !legal) err_illegal <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            lcd_cmd       <= fifo_head;
            lcd_cmd_valid <= 1'b1;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          lcd_cmd       <= NOP_CODE;
          lcd_cmd_valid <= 1'b0;
          if (issued_cnt != '1) issued_cnt <= issued_cnt + CNT_W'(1);
          state <= (lcd_cmd == CMD_WRITE) ? ST_WAIT_DONE : ST_GUARD;
        end
        ST_GUARD: begin
          state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!lcd_busy) state <= ST_IDLE;
        end
        ST_WAIT_DONE: begin
          if (lcd_done) begin
            seq_done <= 1'b1;
            state    <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          state <= ST_FINISH;
        end
        default: begin
          state         <= ST_IDLE;
          lcd_cmd       <= NOP_CODE;
          lcd_cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lcd_cmd_sequencer : directed self-checking bench                  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_lcd_cmd_sequencer;

  logic       clk;
  logic       reset;
  logic       busy_drv;
  logic       model_en;
  logic       model_busy;
  logic       lcd_busy;
  logic       lcd_done;
  logic [3:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic       seq_done;
  logic [7:0] issued_cnt;
  logic       err_illegal;

  int tests;
  int fails;
  int cyc;
  logic [3:0] rec_code[$];
  int         rec_cyc[$];

  lcd_cmd_sequencer_if host_if ();

  lcd_cmd_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .host          (host_if),
    .lcd_busy      (lcd_busy),
    .lcd_done      (lcd_done),
    .lcd_cmd       (lcd_cmd),
    .lcd_cmd_valid (lcd_cmd_valid),
    .seq_done      (seq_done),
    .issued_cnt    (issued_cnt),
    .err_illegal   (err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller stand-in: busy for one cycle after it samples a strobe.
  always @(posedge clk or posedge reset) begin
    if (reset) model_busy <= 1'b0;
    else       model_busy <= lcd_cmd_valid;
  end
  assign lcd_busy = model_en ? model_busy : busy_drv;

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
    tests++;
    if (lcd_cmd_valid === 1'b0 && lcd_cmd !== 4'hF) begin
      fails++;
      $display("FAIL nop_level: lcd_cmd=%h required F at cycle %0d", lcd_cmd, cyc);
    end
    if (lcd_cmd_valid === 1'b1) begin
      rec_code.push_back(lcd_cmd);
      rec_cyc.push_back(cyc);
    end
  endtask

  task automatic push(input logic [3:0] c);
    host_if.in_cmd   = c;
    host_if.in_valid = 1'b1;
    step();
    host_if.in_valid = 1'b0;
  endtask

  task automatic do_reset(input logic busy_init);
    reset            = 1'b1;
    host_if.in_valid = 1'b0;
    lcd_done         = 1'b0;
    model_en         = 1'b0;
    busy_drv         = busy_init;
    step();
    step();
    reset = 1'b0;
    rec_code.delete();
    rec_cyc.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step();
    tests++;
    if (lcd_cmd !== 4'hF || lcd_cmd_valid !== 1'b0 || seq_done !== 1'b0 ||
        issued_cnt !== 8'd0 || err_illegal !== 1'b0 || host_if.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_values: cmd=%h v=%b done=%b cnt=%0d err=%b rdy=%b required F 0 0 0 0 1",
               lcd_cmd, lcd_cmd_valid, seq_done, issued_cnt, err_illegal, host_if.in_ready);
    end
    do_reset(1'b0);
  endtask

  task automatic test_busy_hold;
    do_reset(1'b1);
    push(4'd1);
    push(4'd5);
    push(4'd0);
    for (int i = 0; i < 61; i++) step();
    tests++;
    if (rec_code.size() != 0) begin
      fails++;
      $display("FAIL busy_hold_nostrobe: strobes=%0d required 0", rec_code.size());
    end
    busy_drv = 1'b0;
    step();
    tests++;
    if (lcd_cmd_valid !== 1'b1 || lcd_cmd !== 4'd1) begin
      fails++;
      $display("FAIL busy_release_latency: v=%b cmd=%h required 1 1", lcd_cmd_valid, lcd_cmd);
    end
    for (int i = 0; i < 3; i++) step();
    tests++;
    if (issued_cnt !== 8'd1 || rec_code.size() != 1) begin
      fails++;
      $display("FAIL busy_gap: cnt=%0d strobes=%0d required 1 1", issued_cnt, rec_code.size());
    end
    step();
    tests++;
    if (lcd_cmd_valid !== 1'b1 || lcd_cmd !== 4'd5) begin
      fails++;
      $display("FAIL second_issue: v=%b cmd=%h required 1 5", lcd_cmd_valid, lcd_cmd);
    end
  endtask

  task automatic test_illegal;
    do_reset(1'b0);
    push(4'd13);
    tests++;
    if (err_illegal !== 1'b1 || dut.fifo_count !== 4'd0 || host_if.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL illegal_drop: err=%b count=%0d rdy=%b required 1 0 1",
               err_illegal, dut.fifo_count, host_if.in_ready);
    end
    for (int i = 0; i < 5; i++) step();
    tests++;
    if (rec_code.size() != 0 || issued_cnt !== 8'd0 || lcd_cmd !== 4'hF) begin
      fails++;
      $display("FAIL illegal_noissue: strobes=%0d cnt=%0d cmd=%h required 0 0 F",
               rec_code.size(), issued_cnt, lcd_cmd);
    end
  endtask

  task automatic test_full;
    do_reset(1'b1);
    for (int i = 0; i < 9; i++) begin
      tests++;
      if (host_if.in_ready !== (i < 8 ? 1'b1 : 1'b0)) begin
        fails++;
        $display("FAIL full_ready[%0d]: rdy=%b required %b", i, host_if.in_ready, (i < 8));
      end
      push(4'd4);
    end
    tests++;
    if (dut.fifo_count !== 4'd8 || host_if.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_count: count=%0d rdy=%b required 8 0", dut.fifo_count, host_if.in_ready);
    end
    busy_drv = 1'b0;
    for (int i = 0; i < 60; i++) step();
    tests++;
    if (rec_code.size() != 8 || issued_cnt !== 8'd8 || dut.fifo_count !== 4'd0) begin
      fails++;
      $display("FAIL full_drain: strobes=%0d cnt=%0d count=%0d required 8 8 0",
               rec_code.size(), issued_cnt, dut.fifo_count);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_codes [3];
    exp_codes = '{4'd2, 4'd3, 4'd7};
    do_reset(1'b0);
    model_en = 1'b1;
    push(4'd2);
    push(4'd3);
    push(4'd7);
    for (int i = 0; i < 30; i++) step();
    tests++;
    if (rec_code.size() != 3 || issued_cnt !== 8'd3) begin
      fails++;
      $display("FAIL b2b_count: strobes=%0d cnt=%0d required 3 3", rec_code.size(), issued_cnt);
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (rec_code[i] !== exp_codes[i]) begin
          fails++;
          $display("FAIL b2b_code[%0d]: got %h required %h", i, rec_code[i], exp_codes[i]);
        end
        if (i > 0) begin
          tests++;
          if (rec_cyc[i] - rec_cyc[i-1] < 3) begin
            fails++;
            $display("FAIL b2b_gap[%0d]: gap=%0d required >=3", i, rec_cyc[i] - rec_cyc[i-1]);
          end
        end
      end
    end
    model_en = 1'b0;
  endtask

  task automatic test_write_done;
    int   budget;
    logic early;
    do_reset(1'b0);
    push(4'd0);
    budget = 0;
    while (rec_code.size() == 0 && budget < 10) begin
      step();
      budget++;
    end
    tests++;
    if (rec_code.size() != 1 || rec_code[0] !== 4'd0) begin
      fails++;
      $display("FAIL write_issue: strobes=%0d required 1 (code 0)", rec_code.size());
    end
    early = 1'b0;
    for (int i = 0; i < 65; i++) begin
      step();
      if (seq_done !== 1'b0) early = 1'b1;
    end
    tests++;
    if (early !== 1'b0) begin
      fails++;
      $display("FAIL write_early_done: seq_done rose before lcd_done, required 0");
    end
    lcd_done = 1'b1;
    step();
    lcd_done = 1'b0;
    tests++;
    if (seq_done !== 1'b1 || host_if.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL write_done: done=%b rdy=%b required 1 0", seq_done, host_if.in_ready);
    end
    push(4'd3);
    for (int i = 0; i < 10; i++) step();
    tests++;
    if (rec_code.size() != 1 || issued_cnt !== 8'd1 || seq_done !== 1'b1 || dut.fifo_count !== 4'd0) begin
      fails++;
      $display("FAIL finish_terminal: strobes=%0d cnt=%0d done=%b count=%0d required 1 1 1 0",
               rec_code.size(), issued_cnt, seq_done, dut.fifo_count);
    end
  endtask

  task automatic test_reset_mid;
    int budget;
    do_reset(1'b0);
    push(4'd13);
    push(4'd6);
    budget = 0;
    while (rec_code.size() == 0 && budget < 10) begin
      step();
      budget++;
    end
    busy_drv = 1'b1;
    push(4'd8);
    push(4'd9);
    push(4'd10);
    tests++;
    if (dut.fifo_count !== 4'd3 || issued_cnt !== 8'd1 || err_illegal !== 1'b1) begin
      fails++;
      $display("FAIL midreset_setup: count=%0d cnt=%0d err=%b required 3 1 1",
               dut.fifo_count, issued_cnt, err_illegal);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (lcd_cmd !== 4'hF || lcd_cmd_valid !== 1'b0 || issued_cnt !== 8'd0 || err_illegal !== 1'b0 ||
        seq_done !== 1'b0 || host_if.in_ready !== 1'b1 || dut.fifo_count !== 4'd0) begin
      fails++;
      $display("FAIL midreset_async: cmd=%h v=%b cnt=%0d err=%b done=%b rdy=%b count=%0d required F 0 0 0 0 1 0",
               lcd_cmd, lcd_cmd_valid, issued_cnt, err_illegal, seq_done, host_if.in_ready, dut.fifo_count);
    end
    busy_drv = 1'b0;
    step();
    reset = 1'b0;
    rec_code.delete();
    rec_cyc.delete();
    for (int i = 0; i < 20; i++) step();
    tests++;
    if (rec_code.size() != 0) begin
      fails++;
      $display("FAIL midreset_discard: strobes=%0d required 0", rec_code.size());
    end
    push(4'd5);
    for (int i = 0; i < 5; i++) step();
    tests++;
    if (rec_code.size() != 1 || rec_code[0] !== 4'd5) begin
      fails++;
      $display("FAIL midreset_resume: strobes=%0d required 1 (code 5)", rec_code.size());
    end
  endtask

  initial begin
    tests            = 0;
    fails            = 0;
    cyc              = 0;
    reset            = 1'b1;
    busy_drv         = 1'b0;
    model_en         = 1'b0;
    lcd_done         = 1'b0;
    host_if.in_cmd   = 4'd0;
    host_if.in_valid = 1'b0;
    test_reset();
    test_busy_hold();
    test_illegal();
    test_full();
    test_back_to_back();
    test_write_done();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
